// File: rtl/trace_trigger_filter_pkg.sv
// -----------------------------------------------------------------------------
// trace_trigger_filter_pkg
//   Shared definitions for the trace trigger filter: control register map,
//   trigger FSM states, address-range register layout and resync timer
//   constants.
//
//   Control map (CTRL_ADDR_WIDTH = 8, CTRL_DATA_WIDTH = 64):
//     0x00 START_EN     wdata[0]; writing also restarts the trigger FSM
//     0x01 START_ADDR   start trigger PC
//     0x02 END_EN       wdata[0]
//     0x03 END_ADDR     end trigger PC
//     0x04 WFI_REACHED  any write clears the sticky WFI flag
//     0x10 + 4*i + f    range channel i, field f = {LO_EN, HI_EN, LO, HI}
// -----------------------------------------------------------------------------
package trace_trigger_filter_pkg;

    localparam int CTRL_ADDR_WIDTH = 8;
    localparam int CTRL_DATA_WIDTH = 64;

    // Upper bound on address-range channels; the register map has room for 16.
    localparam int MAX_RANGES = 16;

    localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;

    // Consecutive dropped packets tolerated before one is forced through.
    localparam int                            RESYNC_TIMER_WIDTH       = 8;
    localparam logic [RESYNC_TIMER_WIDTH-1:0] RESYNC_TIMER_RESET_VALUE = 8'd10;

    typedef enum logic [CTRL_ADDR_WIDTH-1:0] {
        CTRL_START_EN    = 8'h00,
        CTRL_START_ADDR  = 8'h01,
        CTRL_END_EN      = 8'h02,
        CTRL_END_ADDR    = 8'h03,
        CTRL_WFI_REACHED = 8'h04,
        CTRL_RANGE_BASE  = 8'h10
    } ctrl_addr_t;

    localparam logic [CTRL_ADDR_WIDTH-1:0] RANGE_BASE = CTRL_RANGE_BASE;

    typedef enum logic [1:0] {
        RANGE_LO_EN = 2'd0,
        RANGE_HI_EN = 2'd1,
        RANGE_LO    = 2'd2,
        RANGE_HI    = 2'd3
    } range_field_t;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        TRACING    = 2'd1,
        STOPPED    = 2'd2
    } trig_state_t;

    // Control address of one field of one range channel.
    function automatic logic [CTRL_ADDR_WIDTH-1:0] range_reg_addr(
        input int           ch,
        input range_field_t field
    );
        return CTRL_ADDR_WIDTH'(int'(RANGE_BASE) + 4 * ch + int'(field));
    endfunction

endpackage

// File: rtl/trace_trigger_filter_if.sv
// -----------------------------------------------------------------------------
// trace_trigger_filter_if
//   Bundles the trace packet input handshake, the control write port and the
//   filtered packet output handshake of trace_trigger_filter.
//
//   Signals:
//     in_valid/in_ready/in_pc/in_instr   packet from the CPU trace tap
//     ctrl_wr_en/ctrl_addr/ctrl_wdata    control register writes
//     out_valid/out_ready/out_data       filtered packet {instr, pc}
//     out_resync                         packet forced by the resync timer
//
//   Modports:
//     master  trace source / control host / downstream sink side
//     slave   the filter itself
// -----------------------------------------------------------------------------
interface trace_trigger_filter_if
    import trace_trigger_filter_pkg::*;
#(
    parameter int XLEN = 64
);
    logic                       in_valid;
    logic                       in_ready;
    logic [XLEN-1:0]            in_pc;
    logic [31:0]                in_instr;

    logic                       ctrl_wr_en;
    logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr;
    logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata;

    logic                       out_valid;
    logic                       out_ready;
    logic [32+XLEN-1:0]         out_data;
    logic                       out_resync;

    modport master (
        output in_valid, in_pc, in_instr,
        output ctrl_wr_en, ctrl_addr, ctrl_wdata,
        output out_ready,
        input  in_ready, out_valid, out_data, out_resync
    );

    modport slave (
        input  in_valid, in_pc, in_instr,
        input  ctrl_wr_en, ctrl_addr, ctrl_wdata,
        input  out_ready,
        output in_ready, out_valid, out_data, out_resync
    );

endinterface

// File: rtl/trace_trigger_filter_address_range_matcher.sv
// -----------------------------------------------------------------------------
// address_range_matcher
//   One address-range channel: holds its lo/hi bounds and enables, decodes
//   its own four control addresses, and compares the incoming PC.
//
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     i_wr_en      control write strobe
//     i_addr       control address
//     i_wdata      control write data (bounds use the low XLEN bits)
//     i_pc         PC to classify
//     o_active     channel has at least one bound enabled
//     o_match      PC satisfies every enabled bound (inclusive, unsigned)
// -----------------------------------------------------------------------------
module address_range_matcher
    import trace_trigger_filter_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int CH_INDEX = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [CTRL_ADDR_WIDTH-1:0] i_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] i_wdata,
    input  logic [XLEN-1:0]            i_pc,
    output logic                       o_active,
    output logic                       o_match
);

    localparam logic [CTRL_ADDR_WIDTH-1:0] A_LO_EN = range_reg_addr(CH_INDEX, RANGE_LO_EN);
    localparam logic [CTRL_ADDR_WIDTH-1:0] A_HI_EN = range_reg_addr(CH_INDEX, RANGE_HI_EN);
    localparam logic [CTRL_ADDR_WIDTH-1:0] A_LO    = range_reg_addr(CH_INDEX, RANGE_LO);
    localparam logic [CTRL_ADDR_WIDTH-1:0] A_HI    = range_reg_addr(CH_INDEX, RANGE_HI);

    logic            r_lo_en;
    logic            r_hi_en;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_hi;

    // NOTE: state is assigned with <= so every register samples the values
    // from before the edge, independent of statement order.
    // NOTE: these are a handful of config flops, not a RAM, so resetting them
    // costs nothing and gives a known "channel disabled" state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo_en <= 1'b0;
            r_hi_en <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else if (i_wr_en) begin
            if (i_addr == A_LO_EN) r_lo_en <= i_wdata[0];
            if (i_addr == A_HI_EN) r_hi_en <= i_wdata[0];
            if (i_addr == A_LO)    r_lo    <= i_wdata[XLEN-1:0];
            if (i_addr == A_HI)    r_hi    <= i_wdata[XLEN-1:0];
        end
    end

    assign o_active = r_lo_en || r_hi_en;

    // lo > hi with both bounds enabled can never satisfy both terms: no wrap.
    assign o_match = (!r_lo_en || (i_pc >= r_lo)) &&
                     (!r_hi_en || (i_pc <= r_hi));

endmodule

// File: rtl/trace_trigger_filter.sv
// -----------------------------------------------------------------------------
// trace_trigger_filter
//   Sits between the CPU trace tap and the trace FIFO. Accepts {instr, pc}
//   packets, gates them by a start/end trigger FSM and by NUM_RANGES
//   programmable address ranges, and emits survivors through a one-deep
//   registered valid/ready stage. Also raises a sticky flag on WFI.
//
//   Optional feature: define TRACE_TRIGGER_RESYNC_EN to add the resync timer,
//   which forces one packet through (out_resync=1) after a run of
//   RESYNC_TIMER_RESET_VALUE consecutive range drops while tracing.
//   Without it out_resync is tied 0.
//
//   Ports:
//     clk            clock, rising edge
//     rst            asynchronous active-high reset
//     bus            trace_trigger_filter_if.slave (packet in, ctrl, packet out)
//     o_range_hit    per-channel hit of the last accepted packet
//     o_tracing      trigger FSM is in TRACING
//     o_wfi_reached  sticky: an accepted packet carried WFI
//
//   Requires XLEN <= CTRL_DATA_WIDTH and 1 <= NUM_RANGES <= MAX_RANGES.
// -----------------------------------------------------------------------------
module trace_trigger_filter
    import trace_trigger_filter_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NUM_RANGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    trace_trigger_filter_if.slave bus,
    output logic [NUM_RANGES-1:0] o_range_hit,
    output logic                  o_tracing,
    output logic                  o_wfi_reached
);

    // ---------------------------------------------------------------- inputs
    logic                       w_accept;
    logic [XLEN-1:0]            w_pc;
    logic                       w_wr;
    logic [CTRL_ADDR_WIDTH-1:0] w_addr;
    logic [CTRL_DATA_WIDTH-1:0] w_wdata;
    logic                       w_start_en_wr;

    logic                       r_out_valid;
    logic [32+XLEN-1:0]         r_out_data;

    assign w_pc          = bus.in_pc;
    assign w_wr          = bus.ctrl_wr_en;
    assign w_addr        = bus.ctrl_addr;
    assign w_wdata       = bus.ctrl_wdata;
    assign w_start_en_wr = w_wr && (w_addr == CTRL_START_EN);

    // The output slot is free when empty or being drained this cycle.
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // ------------------------------------------------------- trigger config
    logic            r_start_en;
    logic [XLEN-1:0] r_start_addr;
    logic            r_end_en;
    logic [XLEN-1:0] r_end_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_en   <= 1'b0;
            r_start_addr <= '0;
            r_end_en     <= 1'b0;
            r_end_addr   <= '0;
        end else if (w_wr) begin
            case (w_addr)
                CTRL_START_EN:   r_start_en   <= w_wdata[0];
                CTRL_START_ADDR: r_start_addr <= w_wdata[XLEN-1:0];
                CTRL_END_EN:     r_end_en     <= w_wdata[0];
                CTRL_END_ADDR:   r_end_addr   <= w_wdata[XLEN-1:0];
                default:         ;
            endcase
        end
    end

    // -------------------------------------------------------- range channels
    logic [NUM_RANGES-1:0] w_active;
    logic [NUM_RANGES-1:0] w_match;
    logic [NUM_RANGES-1:0] w_hit;
    logic                  w_in_range;

    for (genvar g = 0; g < NUM_RANGES; g++) begin : g_ch
        if (g < MAX_RANGES) begin : g_inst
            address_range_matcher #(
                .XLEN     (XLEN),
                .CH_INDEX (g)
            ) u_matcher (
                .clk      (clk),
                .rst      (rst),
                .i_wr_en  (w_wr),
                .i_addr   (w_addr),
                .i_wdata  (w_wdata),
                .i_pc     (w_pc),
                .o_active (w_active[g]),
                .o_match  (w_match[g])
            );
        end else begin : g_none
            // Beyond the register map: permanently inactive.
            assign w_active[g] = 1'b0;
            assign w_match[g]  = 1'b0;
        end
    end

    // An inactive channel trivially "matches", so mask with active before
    // reporting or OR-ing; with no channel active everything is in range.
    assign w_hit      = w_match & w_active;
    assign w_in_range = (w_active == '0) || (|w_hit);

    // ------------------------------------------------------------ trigger FSM
    trig_state_t r_state;
    logic        r_tracing;
    logic        w_start_match;
    logic        w_end_match;
    logic        w_trace_ok;

    assign w_start_match = (w_pc == r_start_addr);
    assign w_end_match   = r_end_en && (w_pc == r_end_addr);

    // The packet that fires the start trigger is itself traced.
    assign w_trace_ok = (r_state == TRACING) ||
                        ((r_state == WAIT_START) && w_start_match);

    // A start_en write restarts the trigger regardless of any packet in the
    // same cycle; otherwise accepted packets drive the transitions. In
    // WAIT_START only the start compare is looked at, so pc==start==end
    // lands in TRACING and the end match is ignored for that packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= TRACING;
            r_tracing <= 1'b1;
        end else if (w_start_en_wr) begin
            r_state   <= w_wdata[0] ? WAIT_START : TRACING;
            r_tracing <= !w_wdata[0];
        end else if (w_accept) begin
            case (r_state)
                WAIT_START: begin
                    if (w_start_match) begin
                        r_state   <= TRACING;
                        r_tracing <= 1'b1;
                    end
                end
                TRACING: begin
                    if (w_end_match) begin
                        r_state   <= r_start_en ? WAIT_START : STOPPED;
                        r_tracing <= 1'b0;
                    end
                end
                STOPPED: ;
                default: begin
                    r_state   <= TRACING;
                    r_tracing <= 1'b1;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- resync timer
    logic w_force;
    logic w_forward;

    assign w_forward = w_accept && w_trace_ok && (w_in_range || w_force);

`ifdef TRACE_TRIGGER_RESYNC_EN
    logic [RESYNC_TIMER_WIDTH-1:0] r_drop_cnt;
    logic                          w_resync_due;
    logic                          r_out_resync;

    assign w_resync_due = (r_drop_cnt == RESYNC_TIMER_RESET_VALUE);
    // Only an out-of-range packet is "forced"; an in-range one would have
    // been forwarded anyway.
    assign w_force      = w_resync_due && !w_in_range;

    // While TRACING the only reason to drop an accepted packet is the range
    // filter, so that is the run being counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_start_en_wr || w_forward) begin
            r_drop_cnt <= '0;
        end else if (w_accept && (r_state == TRACING) && !w_resync_due) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_resync <= 1'b0;
        end else if (w_forward) begin
            r_out_resync <= w_force;
        end else if (bus.out_ready) begin
            r_out_resync <= 1'b0;
        end
    end

    assign bus.out_resync = r_out_resync;
`else
    assign w_force        = 1'b0;
    assign bus.out_resync = 1'b0;
`endif

    // ----------------------------------------------------------- output stage
    // Loading only happens on an accept, and accept implies the slot is free,
    // so a stalled packet is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_forward) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {bus.in_instr, w_pc};
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    // ------------------------------------------------------- status outputs
    logic [NUM_RANGES-1:0] r_range_hit;
    logic                  r_wfi_reached;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_hit <= '0;
        end else if (w_accept) begin
            r_range_hit <= w_hit;
        end
    end

    // Set has priority over a clear write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wfi_reached <= 1'b0;
        end else if (w_accept && (bus.in_instr == WFI_INSTRUCTION)) begin
            r_wfi_reached <= 1'b1;
        end else if (w_wr && (w_addr == CTRL_WFI_REACHED)) begin
            r_wfi_reached <= 1'b0;
        end
    end

    assign o_range_hit   = r_range_hit;
    assign o_tracing     = r_tracing;
    assign o_wfi_reached = r_wfi_reached;

endmodule
